// File: rtl/cla_seq_adder_pkg.sv
// Shared types and helpers for the sequential carry-lookahead adder.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2, used to size the slice index counter.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cla_seq_adder_if.sv
// Operand and result handshakes of the sequential adder, bundled.
interface cla_seq_adder_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/cla_seq_adder_group.sv
// GROUP-bit carry-lookahead slice: every internal carry is formed from the
// prefix generate/propagate terms and the slice carry-in, not rippled.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             c,
  output logic [GROUP-1:0] s,
  output logic             c_out,
  output logic             c_msb,
  output logic             P,
  output logic             G
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP:0]   carry;
  logic             g_acc;
  logic             p_acc;

  assign g = a & b;
  assign p = a | b;

  // Prefix lookahead: carry[i+1] = G[i:0] | (P[i:0] & c).
  always_comb begin
    g_acc    = 1'b0;
    p_acc    = 1'b1;
    carry    = '0;
    carry[0] = c;
    for (int i = 0; i < GROUP; i++) begin
      g_acc        = g[i] | (p[i] & g_acc);
      p_acc        = p_acc & p[i];
      carry[i+1]   = g_acc | (p_acc & c);
    end
  end

  assign s     = a ^ b ^ carry[GROUP-1:0];
  assign c_out = carry[GROUP];
  assign c_msb = carry[GROUP-1];
  assign P     = p_acc;
  assign G     = g_acc;

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle adder/subtractor: resolves GROUP bits per cycle through one
// shared lookahead slice, chaining the slice carry through a register.
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  cla_seq_adder_if.slave  bus
);

  localparam int NG   = WIDTH / GROUP;
  localparam int IDXW = (NG > 1) ? clog2(NG) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NG - 1);

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic [IDXW-1:0]  idx;
  logic             cout_reg;
  logic             ovf_reg;
  logic             out_valid_reg;

  logic [GROUP-1:0] slice_a;
  logic [GROUP-1:0] slice_b;
  logic [GROUP-1:0] slice_s;
  logic             slice_cout;
  logic             slice_cmsb;
  logic             slice_p;
  logic             slice_g;

  assign slice_a = a_reg[int'(idx)*GROUP +: GROUP];
  assign slice_b = b_reg[int'(idx)*GROUP +: GROUP];

  cla_group #(.GROUP(GROUP)) u_group (
    .a     (slice_a),
    .b     (slice_b),
    .c     (carry_reg),
    .s     (slice_s),
    .c_out (slice_cout),
    .c_msb (slice_cmsb),
    .P     (slice_p),
    .G     (slice_g)
  );

  // Control FSM plus operand, partial-sum, carry and index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      sum_reg       <= '0;
      carry_reg     <= 1'b0;
      idx           <= '0;
      cout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b ^ {WIDTH{bus.sub}};
            carry_reg <= bus.cin ^ bus.sub;
            idx       <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          sum_reg[int'(idx)*GROUP +: GROUP] <= slice_s;
          carry_reg <= slice_g | (slice_p & carry_reg);
          if (idx == LAST_IDX) begin
            cout_reg      <= slice_cout;
            ovf_reg       <= slice_cmsb ^ slice_cout;
            out_valid_reg <= 1'b1;
            idx           <= '0;
            state         <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;
  assign bus.overflow  = ovf_reg;

endmodule
